// File: rtl/hermes_switch_ctrl.sv
// Hermes mesh router switch control: round-robin header arbitration, XY
// routing, output allocation and the input/output connection table that
// steers the crossbar. Port order: 0 EAST, 1 WEST, 2 NORTH, 3 SOUTH,
// 4.. LOCAL0..LOCALn.
// Optional: define HERMES_SWITCH_STATS_EN to add saturating grant/block
// counters (grant_cnt_o, block_cnt_o).
module hermes_switch_ctrl #(
  parameter int  NLOCAL    = 1,
  parameter int  COORD_W   = 4,
  parameter int  FLIT_SIZE = 16,
  localparam int NPORT     = 4 + NLOCAL,
  localparam int LSEL_W    = (NLOCAL > 1) ? $clog2(NLOCAL) : 1,
  localparam int PSEL_W    = $clog2(NPORT)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [2*COORD_W-1:0]        address_i,
  input  logic [NPORT-1:0]            req_i,
  input  logic [NPORT*FLIT_SIZE-1:0]  header_i,
  input  logic [NPORT-1:0]            release_i,
  output logic [NPORT-1:0]            ack_h_o,
  output logic [NPORT*PSEL_W-1:0]     in_sel_o,
  output logic [NPORT*PSEL_W-1:0]     out_sel_o,
  output logic [NPORT-1:0]            out_busy_o,
  output logic [NPORT-1:0]            in_conn_o
`ifdef HERMES_SWITCH_STATS_EN
  ,
  output logic [31:0]                 grant_cnt_o,
  output logic [31:0]                 block_cnt_o
`endif
);

  // Only the routing fields of a header are kept after arbitration.
  localparam int HW_W = 2*COORD_W + LSEL_W;

  typedef enum logic [1:0] {IDLE, ARB, ROUTE, GRANT} state_t;

  state_t                         state_q, state_d;
  logic [NPORT-1:0][FLIT_SIZE-1:0] hdr_arr;
  logic [NPORT-1:0]               elig;
  logic [PSEL_W-1:0]              ptr_q, sel_q, pick, dest;
  logic [HW_W-1:0]                hdr_q;
  logic [NPORT-1:0][PSEL_W-1:0]   in_sel_q, out_sel_q;
  logic                           do_latch, do_block, do_grant;
  logic [COORD_W-1:0]             tx, ty, rx, ry;
  logic [LSEL_W-1:0]              lsel;
  logic                           unused_hdr;

  assign hdr_arr    = header_i;
  assign unused_hdr = ^header_i;
  assign elig       = req_i & ~in_conn_o;
  assign in_sel_o   = in_sel_q;
  assign out_sel_o  = out_sel_q;

  assign tx   = hdr_q[2*COORD_W-1:COORD_W];
  assign ty   = hdr_q[COORD_W-1:0];
  assign lsel = hdr_q[HW_W-1:2*COORD_W];
  assign rx   = address_i[2*COORD_W-1:COORD_W];
  assign ry   = address_i[COORD_W-1:0];

  // Round-robin pick: first eligible input strictly after the pointer.
  // Scanning distances from far to near lets the nearest one win.
  always_comb begin
    pick = '0;
    for (int k = NPORT; k >= 1; k--) begin
      for (int i = 0; i < NPORT; i++) begin
        if (elig[i] && ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + NPORT)))
          pick = PSEL_W'(i);
      end
    end
  end

  // XY route of the latched header; out-of-range local select falls to LOCAL0.
  always_comb begin
    if (tx > rx)                   dest = PSEL_W'(0);
    else if (tx < rx)              dest = PSEL_W'(1);
    else if (ty > ry)              dest = PSEL_W'(2);
    else if (ty < ry)              dest = PSEL_W'(3);
    else if (int'(lsel) < NLOCAL)  dest = PSEL_W'(4 + int'(lsel));
    else                           dest = PSEL_W'(4);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_d  = state_q;
    do_latch = 1'b0;
    do_block = 1'b0;
    do_grant = 1'b0;
    case (state_q)
      IDLE:  if (|elig) state_d = ARB;
      ARB: begin
        if (|elig) begin
          do_latch = 1'b1;
          state_d  = ROUTE;
        end else begin
          state_d  = IDLE;
        end
      end
      // Busy is checked against the registered table, so a release landing
      // in this same cycle cannot rescue the request; it simply retries.
      ROUTE: begin
        if (out_busy_o[dest]) begin
          do_block = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = GRANT;
        end
      end
      GRANT: begin
        do_grant = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration registers and connection table. Releases are applied first
  // so a grant on another port in the same cycle lands on top of them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q      <= PSEL_W'(NPORT-1);
      sel_q      <= '0;
      hdr_q      <= '0;
      ack_h_o    <= '0;
      out_busy_o <= '0;
      in_conn_o  <= '0;
      in_sel_q   <= '0;
      out_sel_q  <= '0;
    end else begin
      ack_h_o <= '0;
      for (int i = 0; i < NPORT; i++) begin
        if (release_i[i] && in_conn_o[i]) begin
          in_conn_o[i]              <= 1'b0;
          out_busy_o[out_sel_q[i]]  <= 1'b0;
        end
      end
      if (do_latch) begin
        sel_q <= pick;
        hdr_q <= hdr_arr[pick][HW_W-1:0];
      end
      if (do_block) ptr_q <= sel_q;
      if (do_grant) begin
        ack_h_o[sel_q]    <= 1'b1;
        out_busy_o[dest]  <= 1'b1;
        in_conn_o[sel_q]  <= 1'b1;
        in_sel_q[dest]    <= sel_q;
        out_sel_q[sel_q]  <= dest;
        ptr_q             <= sel_q;
      end
    end
  end

`ifdef HERMES_SWITCH_STATS_EN
  // Saturating grant / block event counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grant_cnt_o <= '0;
      block_cnt_o <= '0;
    end else begin
      if (do_grant && grant_cnt_o != '1) grant_cnt_o <= grant_cnt_o + 32'd1;
      if (do_block && block_cnt_o != '1) block_cnt_o <= block_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hermes_switch_ctrl.sv
// Bench for hermes_switch_ctrl: directed scenarios plus randomized request /
// release traffic, with every cycle compared against a transaction-level
// reference of the switch table kept here. A second instance with NLOCAL=3
// covers local-select clamping.
module tb_hermes_switch_ctrl;
  localparam int NL  = 2;
  localparam int NP  = 4 + NL;
  localparam int PW  = 3;
  localparam int FS  = 16;
  localparam int NL2 = 3;
  localparam int NP2 = 4 + NL2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] addr = 8'h22;

  logic [NP-1:0]          req, rel, ack, busy, conn;
  logic [NP-1:0][FS-1:0]  hdr;
  logic [NP*PW-1:0]       in_sel, out_sel;

  logic [NP2-1:0]         req2, rel2, ack2, busy2, conn2;
  logic [NP2-1:0][FS-1:0] hdr2;
  logic [NP2*PW-1:0]      in_sel2, out_sel2;

`ifdef HERMES_SWITCH_STATS_EN
  logic [31:0] gcnt, bcnt, gcnt2, bcnt2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hermes_switch_ctrl #(.NLOCAL(NL), .COORD_W(4), .FLIT_SIZE(FS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .address_i(addr), .req_i(req),
    .header_i(hdr), .release_i(rel), .ack_h_o(ack), .in_sel_o(in_sel),
    .out_sel_o(out_sel), .out_busy_o(busy), .in_conn_o(conn)
`ifdef HERMES_SWITCH_STATS_EN
    , .grant_cnt_o(gcnt), .block_cnt_o(bcnt)
`endif
  );

  hermes_switch_ctrl #(.NLOCAL(NL2), .COORD_W(4), .FLIT_SIZE(FS)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .address_i(addr), .req_i(req2),
    .header_i(hdr2), .release_i(rel2), .ack_h_o(ack2), .in_sel_o(in_sel2),
    .out_sel_o(out_sel2), .out_busy_o(busy2), .in_conn_o(conn2)
`ifdef HERMES_SWITCH_STATS_EN
    , .grant_cnt_o(gcnt2), .block_cnt_o(bcnt2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase 0 waiting, 1 arbitrating, 2 routing, 3 granting.
  int            m_ptr, m_ph, m_sel, m_dest;
  logic [FS-1:0] m_hdr;
  logic [NP-1:0] m_ack, m_busy, m_conn;
  int            m_isel[NP];
  int            m_osel[NP];
  logic [31:0]   m_g, m_b;
  bit            m_ok = 1'b0;

  function automatic int route(input logic [FS-1:0] h);
    int tx, ty, rx, ry, ls;
    tx = int'(h[7:4]); ty = int'(h[3:0]);
    rx = int'(addr[7:4]); ry = int'(addr[3:0]);
    ls = int'(h[8]);
    if (tx > rx) return 0;
    if (tx < rx) return 1;
    if (ty > ry) return 2;
    if (ty < ry) return 3;
    return (ls < NL) ? 4 + ls : 4;
  endfunction

  always @(posedge clk) begin
    logic [NP-1:0] el, bo, co;
    int d;
    bit found;
    if (!rst_n) begin
      m_ptr = NP - 1; m_ph = 0; m_sel = 0; m_dest = 0; m_hdr = '0;
      m_ack = '0; m_busy = '0; m_conn = '0; m_g = 0; m_b = 0;
      for (int i = 0; i < NP; i++) begin m_isel[i] = 0; m_osel[i] = 0; end
      m_ok = 1'b1;
    end else if (m_ok) begin
      el = req & ~m_conn;
      bo = m_busy;
      co = m_conn;
      m_ack = '0;
      for (int i = 0; i < NP; i++)
        if (rel[i] && co[i]) begin m_conn[i] = 1'b0; m_busy[m_osel[i]] = 1'b0; end
      case (m_ph)
        0: if (el != 0) m_ph = 1;
        1: begin
          if (el == 0) m_ph = 0;
          else begin
            found = 1'b0;
            for (int k = 1; k <= NP; k++) begin
              int c;
              c = (m_ptr + k) % NP;
              if (!found && el[c]) begin m_sel = c; found = 1'b1; end
            end
            m_hdr = hdr[m_sel];
            m_ph = 2;
          end
        end
        2: begin
          d = route(m_hdr);
          if (bo[d]) begin
            m_ptr = m_sel; m_ph = 0;
            if (m_b != 32'hFFFF_FFFF) m_b = m_b + 1;
          end else begin
            m_dest = d; m_ph = 3;
          end
        end
        default: begin
          m_ack[m_sel] = 1'b1; m_busy[m_dest] = 1'b1; m_conn[m_sel] = 1'b1;
          m_isel[m_dest] = m_sel; m_osel[m_sel] = m_dest;
          m_ptr = m_sel; m_ph = 0;
          if (m_g != 32'hFFFF_FFFF) m_g = m_g + 1;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model (sel fields only where valid).
  always @(negedge clk) begin
    if (m_ok) begin
      chk("ack", ack, m_ack);
      chk("busy", busy, m_busy);
      chk("conn", conn, m_conn);
      for (int o = 0; o < NP; o++)
        if (m_busy[o]) chk("in_sel", in_sel[o*PW +: PW], m_isel[o]);
      for (int i = 0; i < NP; i++)
        if (m_conn[i]) chk("out_sel", out_sel[i*PW +: PW], m_osel[i]);
`ifdef HERMES_SWITCH_STATS_EN
      chk("grant_cnt", gcnt, m_g);
      chk("block_cnt", bcnt, m_b);
`endif
    end
  end

  // Wait at negedges for ack on port p; lat = cycles waited, -1 on timeout.
  task automatic wait_ack(input int p, input int budget, output int lat);
    int c;
    c = 0; lat = -1;
    while (lat < 0 && c < budget) begin
      @(negedge clk); c++;
      if (ack[p]) lat = c;
    end
  endtask

  task automatic pulse_rel(input logic [NP-1:0] m);
    rel = m;
    @(negedge clk);
    rel = '0;
  endtask

  function automatic logic [FS-1:0] rnd_hdr();
    logic [FS-1:0] h;
    h = '0;
    h[7:4] = 4'($urandom_range(1, 3));
    h[3:0] = 4'($urandom_range(1, 3));
    h[8]   = 1'($urandom_range(0, 1));
    return h;
  endfunction

  initial begin
    int l, l2, c;
    logic [NP-1:0] first, a_conn;
    bit seen;
    req = '0; rel = '0; hdr = '0; req2 = '0; rel2 = '0; hdr2 = '0;

    // Reset with every input requesting.
    req = '1;
    for (int i = 0; i < NP; i++) hdr[i] = rnd_hdr();
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conn", conn, 0);
    chk("rst_in_sel", in_sel, 0);
    chk("rst_out_sel", out_sel, 0);
    rst_n = 1'b1;
    c = 0; first = '0;
    while (first == 0 && c < 8) begin @(negedge clk); c++; first = ack; end
    chk("rst_first_grant", first, 6'b000001);
    req = '0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Single route: 0x32 from router 0x22 goes EAST.
    hdr[4] = 16'h0032; req[4] = 1'b1;
    wait_ack(4, 10, l);
    chk("single_lat", l, 4);
    chk("single_busy0", busy[0], 1);
    chk("single_in_sel0", in_sel[0*PW +: PW], 4);
    chk("single_out_sel4", out_sel[4*PW +: PW], 0);
    req[4] = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", ack[4], 0);
    pulse_rel(6'b010000);
    chk("rel_busy0", busy[0], 0);
    chk("rel_conn4", conn[4], 0);

    // Round-robin: 1 and 3 together, then 1 and 4 with 4 favoured.
    hdr[1] = 16'h0032; hdr[3] = 16'h0012; req[1] = 1'b1; req[3] = 1'b1;
    wait_ack(1, 10, l);  req[1] = 1'b0;
    wait_ack(3, 10, l2); req[3] = 1'b0;
    chk("rr_first_1", l, 4);
    chk("rr_gap_3", l2, 4);
    pulse_rel(6'b001010);
    hdr[1] = 16'h0032; hdr[4] = 16'h0023; req[1] = 1'b1; req[4] = 1'b1;
    wait_ack(4, 10, l);  req[4] = 1'b0;
    wait_ack(1, 10, l2); req[1] = 1'b0;
    chk("rr_4_before_1", l, 4);
    chk("rr_then_1", l2, 4);
    chk("rr_busy2", busy[2], 1);
    pulse_rel(6'b010010);

    // Contention on LOCAL0.
    hdr[0] = 16'h0022; req[0] = 1'b1;
    wait_ack(0, 10, l); req[0] = 1'b0;
    chk("cont_hold_ack", l, 4);
    hdr[2] = 16'h0022; req[2] = 1'b1; seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= ack[2]; end
    chk("cont_no_ack", seen, 0);
`ifdef HERMES_SWITCH_STATS_EN
    chk("cont_block_cnt", bcnt, 1);
`endif
    pulse_rel(6'b000001);
    wait_ack(2, 8, l); req[2] = 1'b0;
    chk("cont_retry_lat", (l < 0) ? -1 : l + 1, 4);
    chk("cont_in_sel4", in_sel[4*PW +: PW], 2);
    pulse_rel(6'b000100);

    // Local select on NLOCAL=2: lsel=1 -> LOCAL1 (port 5).
    hdr[0] = 16'h0122; req[0] = 1'b1;
    wait_ack(0, 10, l); req[0] = 1'b0;
    chk("lsel1_ack", l, 4);
    chk("lsel1_out_sel0", out_sel[0*PW +: PW], 5);
    chk("lsel1_busy5", busy[5], 1);
    pulse_rel(6'b000001);

    // NLOCAL=3 instance: lsel=3 clamps to port 4, lsel=2 reaches port 6.
    hdr2[0] = 16'h0322; req2[0] = 1'b1;
    c = 0; while (!ack2[0] && c < 10) begin @(negedge clk); c++; end
    req2[0] = 1'b0;
    chk("clamp_ack", ack2[0], 1);
    chk("clamp_out_sel0", out_sel2[0*PW +: PW], 4);
    chk("clamp_busy", busy2, 7'b0010000);
    hdr2[1] = 16'h0222; req2[1] = 1'b1;
    c = 0; while (!ack2[1] && c < 10) begin @(negedge clk); c++; end
    req2[1] = 1'b0;
    chk("lsel2_ack", ack2[1], 1);
    chk("lsel2_out_sel1", out_sel2[1*PW +: PW], 6);

    // Reset asserted in the GRANT cycle.
    hdr[3] = 16'h0032; req[3] = 1'b1;
    repeat (3) @(negedge clk);
    chk("midgrant_pre_ack", ack, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midgrant_ack", ack, 0);
    chk("midgrant_busy", busy, 0);
    chk("midgrant_conn", conn, 0);
    chk("midgrant_busy2", busy2, 0);
    rst_n = 1'b1; req = '0; req2 = '0;

    // Randomized traffic.
    a_conn = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      rel = '0;
      for (int i = 0; i < NP; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0; a_conn[i] = 1'b1;
        end else if (a_conn[i] && $urandom_range(0, 7) == 0) begin
          rel[i] = 1'b1; a_conn[i] = 1'b0;
        end else if (!req[i] && !a_conn[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1; hdr[i] = rnd_hdr();
        end else if (!a_conn[i] && $urandom_range(0, 31) == 0) begin
          rel[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0; req = '0; rel = '0; a_conn = '0;
      end
    end
    @(negedge clk);
    req = '0; rel = '0;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
